// File: rtl/resamp_regs_pkg.sv
// Shared constants, FSM state type and byte-lane merge helper for the resampler
// configuration register bank.
package resamp_regs_pkg;

   localparam logic [2:0] OFS_RATE     = 3'd0;
   localparam logic [2:0] OFS_AURATE   = 3'd1;
   localparam logic [2:0] OFS_AUDEC    = 3'd2;
   localparam logic [2:0] OFS_AUSHIFT  = 3'd3;
   localparam logic [2:0] OFS_CTRL     = 3'd4;
   localparam logic [2:0] OFS_STATUS   = 3'd5;

   localparam int unsigned CTRL_COMMIT = 0;
   localparam int unsigned CTRL_AUTO   = 1;
   localparam int unsigned STAT_PEND   = 0;
   localparam int unsigned STAT_OVR    = 1;

   typedef enum logic [0:0] {ST_IDLE, ST_ARMED} chanState_e;

   // Replace only the byte lanes selected by be.
   function automatic logic [31:0] beMerge(input logic [31:0] oldWord,
                                           input logic [31:0] newWord,
                                           input logic [3:0]  be);
      logic [31:0] res;
      res = oldWord;
      for (int n = 0; n < 4; n++) begin
         if (be[n]) res[8*n +: 8] = newWord[8*n +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/resamp_chan_regs.sv
// One channel of the resampler config bank: shadow/active registers, the
// IDLE/ARMED commit FSM and the sticky overrun flag.
module resamp_chan_regs
   import resamp_regs_pkg::*;
#(
   parameter int unsigned RATE_W  = 32,
   parameter int unsigned DEC_W   = 15,
   parameter int unsigned SHIFT_W = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wrEn,
   input  logic [2:0]         ofs,
   input  logic [3:0]         be,
   input  logic [31:0]        dataIn,
   input  logic               chanSync,
   output logic [31:0]        rdData,
   output logic [RATE_W-1:0]  rate,
   output logic [RATE_W-1:0]  auRate,
   output logic [DEC_W-1:0]   auDec,
   output logic [SHIFT_W-1:0] auShift,
   output logic               pending
);

   logic [RATE_W-1:0]  rateSh_q, auRateSh_q;
   logic [DEC_W-1:0]   auDecSh_q;
   logic [SHIFT_W-1:0] auShiftSh_q;
   logic               autoCommit_q, overrun_q;
   chanState_e         state_q, state_d;

   logic [31:0] curWord, wrWord;
   logic        shadowWr, ctrlWr, statusWr, commit, copy, setOvr;

   always_comb begin
      curWord = '0;
      case (ofs)
         OFS_RATE:    curWord[RATE_W-1:0]  = rateSh_q;
         OFS_AURATE:  curWord[RATE_W-1:0]  = auRateSh_q;
         OFS_AUDEC:   curWord[DEC_W-1:0]   = auDecSh_q;
         OFS_AUSHIFT: curWord[SHIFT_W-1:0] = auShiftSh_q;
         OFS_CTRL:    curWord[CTRL_AUTO]   = autoCommit_q;
         OFS_STATUS: begin
            curWord[STAT_PEND] = (state_q == ST_ARMED);
            curWord[STAT_OVR]  = overrun_q;
         end
         default: curWord = '0;
      endcase
   end

   assign rdData   = curWord;
   assign wrWord   = beMerge(curWord, dataIn, be);
   assign shadowWr = wrEn && (ofs <= OFS_AUSHIFT) && (be != 4'b0000);
   assign ctrlWr   = wrEn && (ofs == OFS_CTRL) && be[0];
   assign statusWr = wrEn && (ofs == OFS_STATUS) && be[0];
   assign commit   = (ctrlWr && dataIn[CTRL_COMMIT]) || (autoCommit_q && shadowWr);
   assign pending  = (state_q == ST_ARMED);

   // A commit landing on the copy edge re-arms for the next sync.
   always_comb begin
      state_d = state_q;
      copy    = 1'b0;
      setOvr  = 1'b0;
      unique case (state_q)
         ST_IDLE: if (commit) state_d = ST_ARMED;
         ST_ARMED: begin
            if (commit) setOvr = 1'b1;
            if (chanSync) begin
               copy = 1'b1;
               if (!commit) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rateSh_q     <= '0;
         auRateSh_q   <= '0;
         auDecSh_q    <= '0;
         auShiftSh_q  <= '0;
         autoCommit_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (shadowWr && ofs == OFS_RATE)    rateSh_q    <= wrWord[RATE_W-1:0];
         if (shadowWr && ofs == OFS_AURATE)  auRateSh_q  <= wrWord[RATE_W-1:0];
         if (shadowWr && ofs == OFS_AUDEC)   auDecSh_q   <= wrWord[DEC_W-1:0];
         if (shadowWr && ofs == OFS_AUSHIFT) auShiftSh_q <= wrWord[SHIFT_W-1:0];
         if (ctrlWr) autoCommit_q <= dataIn[CTRL_AUTO];
         if (setOvr) begin
            overrun_q <= 1'b1;
         end else if (statusWr && dataIn[STAT_OVR]) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Copy uses pre-edge shadow, so a same-edge shadow write is not copied.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rate    <= '0;
         auRate  <= '0;
         auDec   <= '0;
         auShift <= '0;
      end else if (copy) begin
         rate    <= rateSh_q;
         auRate  <= auRateSh_q;
         auDec   <= auDecSh_q;
         auShift <= auShiftSh_q;
      end
   end

endmodule

// File: rtl/resamp_cfg_regs.sv
// Multi-channel resampler configuration bank: CPU address decode, registered
// read mux and one resamp_chan_regs instance per channel.
module resamp_cfg_regs
   import resamp_regs_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter logic [11:0] BASE_ADDR = 12'h000,
   parameter int unsigned RATE_W    = 32,
   parameter int unsigned DEC_W     = 15,
   parameter int unsigned SHIFT_W   = 6
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [11:0]                 addr,
   input  logic [31:0]                 dataIn,
   input  logic                        cs,
   input  logic                        wr_en,
   input  logic [3:0]                  be,
   input  logic                        rd_en,
   output logic [31:0]                 dataOut,
   output logic                        rd_valid,
   input  logic [NUM_CH-1:0]           chan_sync,
   output logic [NUM_CH*RATE_W-1:0]    resampleRate,
   output logic [NUM_CH*RATE_W-1:0]    auResampleRate,
   output logic [NUM_CH*DEC_W-1:0]     auDecimation,
   output logic [NUM_CH*SHIFT_W-1:0]   auShift,
   output logic [NUM_CH-1:0]           update_pending
);

   logic        hit;
   logic [2:0]  chSel, ofs;
   logic [1:0]  unusedAddr;
   logic [31:0] chRdData [NUM_CH];
   logic [31:0] rdMux;

   assign hit        = cs && (addr[11:8] == BASE_ADDR[11:8]);
   assign chSel      = addr[7:5];
   assign ofs        = addr[4:2];
   assign unusedAddr = addr[1:0];

   for (genvar i = 0; i < NUM_CH; i++) begin : gChan
      logic chWr;
      assign chWr = hit && wr_en && (chSel == 3'(i));

      resamp_chan_regs #(
         .RATE_W  (RATE_W),
         .DEC_W   (DEC_W),
         .SHIFT_W (SHIFT_W)
      ) uChan (
         .clk      (clk),
         .reset_n  (reset_n),
         .wrEn     (chWr),
         .ofs      (ofs),
         .be       (be),
         .dataIn   (dataIn),
         .chanSync (chan_sync[i]),
         .rdData   (chRdData[i]),
         .rate     (resampleRate[i*RATE_W +: RATE_W]),
         .auRate   (auResampleRate[i*RATE_W +: RATE_W]),
         .auDec    (auDecimation[i*DEC_W +: DEC_W]),
         .auShift  (auShift[i*SHIFT_W +: SHIFT_W]),
         .pending  (update_pending[i])
      );
   end

   // Channel indices at or above NUM_CH never match and read as zero.
   always_comb begin
      rdMux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (hit && chSel == 3'(i)) rdMux = chRdData[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dataOut  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= cs && rd_en;
         if (cs && rd_en) dataOut <= rdMux;
      end
   end

endmodule

// File: tb/tb_resamp_cfg_regs.sv
// Directed self-checking bench for resamp_cfg_regs (NUM_CH=2, default widths).
module tb_resamp_cfg_regs;

   localparam int NCH = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [11:0]   addr = '0;
   logic [31:0]   dataIn = '0;
   logic          cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [3:0]    be = '0;
   logic [31:0]   dataOut;
   logic          rd_valid;
   logic [NCH-1:0] chan_sync = '0;
   logic [NCH*32-1:0] resampleRate, auResampleRate;
   logic [NCH*15-1:0] auDecimation;
   logic [NCH*6-1:0]  auShift;
   logic [NCH-1:0]    update_pending;

   int total = 0;
   int bad = 0;

   resamp_cfg_regs #(.NUM_CH(NCH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .addr           (addr),
      .dataIn         (dataIn),
      .cs             (cs),
      .wr_en          (wr_en),
      .be             (be),
      .rd_en          (rd_en),
      .dataOut        (dataOut),
      .rd_valid       (rd_valid),
      .chan_sync      (chan_sync),
      .resampleRate   (resampleRate),
      .auResampleRate (auResampleRate),
      .auDecimation   (auDecimation),
      .auShift        (auShift),
      .update_pending (update_pending)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] regAddr(input int ch, input int ofs);
      return 12'(ch * 32 + ofs * 4);
   endfunction

   task automatic busWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      addr = a; dataIn = d; be = b; cs = 1'b1; wr_en = 1'b1;
      @(negedge clk);
      cs = 1'b0; wr_en = 1'b0;
   endtask

   task automatic busRead(input logic [11:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; cs = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      cs = 1'b0; rd_en = 1'b0;
      checkVal("rd_valid", 32'(rd_valid), 32'h1);
      d = dataOut;
   endtask

   task automatic pulseSync(input int ch);
      @(negedge clk);
      chan_sync[ch] = 1'b1;
      @(negedge clk);
      chan_sync = '0;
   endtask

   logic [31:0] rd;

   initial begin
      // Reset state
      #12;
      checkVal("rst_dataOut", dataOut, 32'h0);
      checkVal("rst_rd_valid", 32'(rd_valid), 32'h0);
      checkVal("rst_pending", 32'(update_pending), 32'h0);
      checkVal("rst_rate0", resampleRate[31:0], 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Byte-enable write to ch1 RATE
      busWrite(regAddr(1, 0), 32'hA5A5_1234, 4'b0011);
      busRead(regAddr(1, 0), rd);
      checkVal("be_rate1", rd, 32'h0000_1234);
      @(negedge clk);
      checkVal("rd_valid_drop", 32'(rd_valid), 32'h0);
      checkVal("be_active1", resampleRate[63:32], 32'h0);
      checkVal("be_nopend", 32'(update_pending), 32'h0);

      // Commit ch0
      busWrite(regAddr(0, 0), 32'h0100_0000, 4'b1111);
      busWrite(regAddr(0, 4), 32'h1, 4'b0001);
      checkVal("cm_pend", 32'(update_pending), 32'h1);
      repeat (3) @(negedge clk);
      checkVal("cm_hold", resampleRate[31:0], 32'h0);
      pulseSync(0);
      checkVal("cm_active", resampleRate[31:0], 32'h0100_0000);
      checkVal("cm_pend_drop", 32'(update_pending), 32'h0);
      checkVal("cm_ch1_active", resampleRate[63:32], 32'h0);
      busRead(regAddr(0, 4), rd);
      checkVal("ctrl_reads0", rd, 32'h0);

      // Commit coincident with sync
      busWrite(regAddr(0, 0), 32'h0200_0000, 4'b1111);
      @(negedge clk);
      addr = regAddr(0, 4); dataIn = 32'h1; be = 4'b0001; cs = 1'b1; wr_en = 1'b1;
      chan_sync[0] = 1'b1;
      @(negedge clk);
      cs = 1'b0; wr_en = 1'b0; chan_sync = '0;
      checkVal("co_pend", 32'(update_pending), 32'h1);
      checkVal("co_nocopy", resampleRate[31:0], 32'h0100_0000);
      pulseSync(0);
      checkVal("co_copy", resampleRate[31:0], 32'h0200_0000);
      checkVal("co_pend_drop", 32'(update_pending), 32'h0);

      // Double commit / overrun on ch1
      busWrite(regAddr(1, 4), 32'h1, 4'b0001);
      busWrite(regAddr(1, 4), 32'h1, 4'b0001);
      busRead(regAddr(1, 5), rd);
      checkVal("ovr_stat3", rd, 32'h3);
      busWrite(regAddr(1, 5), 32'h2, 4'b0001);
      busRead(regAddr(1, 5), rd);
      checkVal("ovr_clr", rd, 32'h1);
      pulseSync(1);
      busRead(regAddr(1, 5), rd);
      checkVal("ovr_stat0", rd, 32'h0);
      checkVal("ovr_active1", resampleRate[63:32], 32'h0000_1234);

      // AUTO_COMMIT on ch0
      busWrite(regAddr(0, 4), 32'h2, 4'b0001);
      checkVal("ac_nopend", 32'(update_pending), 32'h0);
      busRead(regAddr(0, 4), rd);
      checkVal("ac_ctrl", rd, 32'h2);
      busWrite(regAddr(0, 3), 32'h0000_002A, 4'b0001);
      checkVal("ac_pend", 32'(update_pending), 32'h1);
      busRead(regAddr(0, 3), rd);
      checkVal("ac_shadow", rd, 32'h2A);
      checkVal("ac_hold", 32'(auShift[5:0]), 32'h0);
      pulseSync(0);
      checkVal("ac_active", 32'(auShift[5:0]), 32'h2A);
      busWrite(regAddr(0, 2), 32'hFFFF_FFFF, 4'b1111);
      busRead(regAddr(0, 2), rd);
      checkVal("dec_trunc", rd, 32'h0000_7FFF);

      // Unmapped and reserved accesses
      busWrite(regAddr(3, 0), 32'hDEAD_BEEF, 4'b1111);
      busRead(regAddr(3, 0), rd);
      checkVal("unmap_rd", rd, 32'h0);
      busRead(regAddr(0, 0), rd);
      checkVal("unmap_ch0", rd, 32'h0200_0000);
      busRead(regAddr(1, 0), rd);
      checkVal("unmap_ch1", rd, 32'h0000_1234);
      busRead(regAddr(0, 6), rd);
      checkVal("resv_rd", rd, 32'h0);

      // Read and write in the same cycle returns pre-write value
      busWrite(regAddr(1, 1), 32'h1111_1111, 4'b1111);
      @(negedge clk);
      addr = regAddr(1, 1); dataIn = 32'h2222_2222; be = 4'b1111;
      cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      checkVal("rw_old", dataOut, 32'h1111_1111);
      busRead(regAddr(1, 1), rd);
      checkVal("rw_new", rd, 32'h2222_2222);

      // Asynchronous reset while ch1 is armed
      busWrite(regAddr(1, 4), 32'h1, 4'b0001);
      checkVal("rr_pend", 32'(update_pending[1]), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      checkVal("rr_pend_drop", 32'(update_pending), 32'h0);
      checkVal("rr_rate0", resampleRate[31:0], 32'h0);
      checkVal("rr_shift0", 32'(auShift[5:0]), 32'h0);
      checkVal("rr_dataOut", dataOut, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      busRead(regAddr(1, 0), rd);
      checkVal("rr_shadow", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
